// File: rtl/video_mode_selector_pkg.sv
// Shared types and constants for the front-panel video mode selector.
//
// Contents:
//   MODE_COUNT       number of entries in the mode table
//   IDX_W            width of a table index
//   MODE_CODE_TABLE  index -> 8-bit decoder code (1080p, 1080i, 720p, 480p, 480i)
//   SelState         selector FSM states
//   step_req_t       per-cycle step requests (next / prev)
//   step_index()     wrap-around table stepping helper
//
// The mode codes normally come from the board header config/video_modes.v.
// The guarded defaults below only apply when that header has not been
// compiled ahead of this package.

`ifndef MODE_1080p
`define MODE_1080p 8'h10
`endif
`ifndef MODE_1080i
`define MODE_1080i 8'h11
`endif
`ifndef MODE_720p
`define MODE_720p 8'h20
`endif
`ifndef MODE_480p
`define MODE_480p 8'h30
`endif
`ifndef MODE_480i
`define MODE_480i 8'h31
`endif

package my_types;

  localparam int MODE_COUNT = 5;
  localparam int IDX_W      = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MODE_COUNT - 1);

  localparam logic [7:0] MODE_CODE_TABLE [0:MODE_COUNT-1] = '{
    `MODE_1080p,
    `MODE_1080i,
    `MODE_720p,
    `MODE_480p,
    `MODE_480i
  };

  typedef enum logic {
    SEL_IDLE,
    SEL_SETTLE
  } SelState;

  typedef struct packed {
    logic next;
    logic prev;
  } step_req_t;

  // One step through the table, wrapping at both ends.
  function automatic logic [IDX_W-1:0] step_index(input logic [IDX_W-1:0] idx,
                                                  input logic             up);
    if (up) return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    else    return (idx == '0) ? LAST_IDX : idx - 1'b1;
  endfunction

endpackage

// File: rtl/video_mode_selector_debounce.sv
// button_debounce: synchroniser, debouncer and rising-edge detector for one
// raw asynchronous pushbutton.
//
// Ports:
//   clock   in  system clock
//   reset   in  synchronous active-high reset
//   button  in  raw async pushbutton, active-high
//   level   out debounced level
//   rise    out one-cycle pulse on an accepted 0->1 transition of level
//
// The first level accepted after reset only primes the detector: a button
// still held across reset therefore never produces a step.

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic rise
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;   // 2-flop synchroniser
  logic             sync_d;   // previous synced value, for change detection
  logic [CNT_W-1:0] cnt;
  logic             primed;
  logic             stable_done;

  // Counter saturates at CNT_MAX, so "stable long enough" is a plain compare.
  assign stable_done = (cnt == CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      sync_d <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      primed <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button};
      sync_d <= sync_q[1];

      if (sync_q[1] != sync_d) cnt <= '0;
      else if (!stable_done)   cnt <= cnt + 1'b1;

      rise <= 1'b0;
      if (stable_done) begin
        level  <= sync_d;
        primed <= 1'b1;
        rise   <= primed & sync_d & ~level;
      end
    end
  end

endmodule

// File: rtl/video_mode_selector.sv
// video_mode_selector: front-panel video mode selector. Debounces the next and
// prev buttons, steps through a five-entry mode table with wrap at both ends,
// and holds off further steps for a settle window after every change so the
// pixel PLL and timing generator can relock.
//
// Ports:
//   clock         in  system clock
//   reset         in  synchronous active-high reset
//   button_next   in  raw async pushbutton, active-high
//   button_prev   in  raw async pushbutton, active-high
//   mode_code     out current 8-bit mode code (registered, glitch-free)
//   mode_index    out current table index 0..4
//   mode_changed  out one-cycle pulse in the cycle mode_code takes a new value
//   busy          out high while the settle window is active
//
// Build option: VIDEO_MODE_SELECT_REPEAT_EN adds auto-repeat on a held button
// (one extra step every REPEAT_CYCLES once the previous settle has ended).
// Without it REPEAT_CYCLES is ignored and no repeat logic exists.

module video_mode_selector
  import my_types::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 2000000,
  parameter int INIT_INDEX      = 0,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             button_next,
  input  logic             button_prev,
  output logic [7:0]       mode_code,
  output logic [IDX_W-1:0] mode_index,
  output logic             mode_changed,
  output logic             busy
);

  localparam int NUM_BTN = 2;   // lane 0 = next, lane 1 = prev
  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;

  localparam int               SET_W       = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] INIT_IDX    = IDX_W'(INIT_INDEX);

  // ---------------------------------------------------------------- buttons
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;

  assign btn_raw = {button_prev, button_next};

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn [NUM_BTN-1:0] (
    .clock  (clock),
    .reset  (reset),
    .button (btn_raw),
    .level  (btn_level),
    .rise   (btn_rise)
  );

  SelState          state, next_state;
  logic [SET_W-1:0] settle_cnt;
  step_req_t        req;

  // ------------------------------------------------------------ auto-repeat
`ifdef VIDEO_MODE_SELECT_REPEAT_EN
  localparam int               RPT_W    = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [NUM_BTN-1:0][RPT_W-1:0] rpt_cnt;
  logic [NUM_BTN-1:0]            rpt_armed;  // a real press started this hold
  logic [NUM_BTN-1:0]            rpt_fire;

  // A timer that expires during SETTLE waits saturated until IDLE.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < NUM_BTN; i++)
      rpt_fire[i] = rpt_armed[i] & btn_level[i] &
                    (rpt_cnt[i] == RPT_LAST) & (state == SEL_IDLE);
  end

  // Timer restarts on release and on the initial press edge; a level that was
  // only primed across reset never arms it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BTN; i++) begin
      if (reset || !btn_level[i]) begin
        rpt_cnt[i]   <= '0;
        rpt_armed[i] <= 1'b0;
      end else if (btn_rise[i]) begin
        rpt_cnt[i]   <= '0;
        rpt_armed[i] <= 1'b1;
      end else if (rpt_fire[i]) begin
        rpt_cnt[i]   <= '0;
      end else if (rpt_cnt[i] != RPT_LAST) begin
        rpt_cnt[i]   <= rpt_cnt[i] + 1'b1;
      end
    end
  end

  assign req = '{next: btn_rise[BTN_NEXT] | rpt_fire[BTN_NEXT],
                 prev: btn_rise[BTN_PREV] | rpt_fire[BTN_PREV]};
`else
  localparam int      unused_repeat = REPEAT_CYCLES;
  logic [NUM_BTN-1:0] unused_level;
  assign unused_level = btn_level;

  assign req = '{next: btn_rise[BTN_NEXT], prev: btn_rise[BTN_PREV]};
`endif

  // -------------------------------------------------------------------- FSM
  logic             do_step;
  logic             step_up;
  logic [IDX_W-1:0] next_index;

  always_comb begin
    next_state = state;
    do_step    = 1'b0;
    step_up    = 1'b0;
    unique case (state)
      SEL_IDLE: begin
        // Simultaneous next+prev is ambiguous and is ignored.
        if (req.next ^ req.prev) begin
          do_step    = 1'b1;
          step_up    = req.next;
          next_state = SEL_SETTLE;
        end
      end
      SEL_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) next_state = SEL_IDLE;
      end
    endcase
  end

  assign next_index = step_index(mode_index, step_up);
  assign busy       = (state == SEL_SETTLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= SEL_IDLE;
      settle_cnt   <= '0;
      mode_index   <= INIT_IDX;
      mode_code    <= MODE_CODE_TABLE[INIT_IDX];
      mode_changed <= 1'b0;
    end else begin
      state        <= next_state;
      mode_changed <= do_step;

      if (state != SEL_SETTLE)            settle_cnt <= '0;
      else if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + 1'b1;

      // Code and index move together, only on a step, so the decoder sees
      // exactly one code change per step.
      if (do_step) begin
        mode_index <= next_index;
        mode_code  <= MODE_CODE_TABLE[next_index];
      end
    end
  end

endmodule
